// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes ALU control fields into an operation code and
// issues it through a valid/ready handshake. Single-cycle ops appear one
// edge after accept; multiply/divide ops wait MUL_LAT/DIV_LAT edges.
// Optional feature: define ALU_MEXT_EN to enable M-extension decode with
// the BUSY state and latency counter; without it f7=0000001 is illegal.
module alu_issue_ctrl #(
   parameter int unsigned OP_W    = 5,
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned DIV_LAT = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [6:0]      funct7,
   input  logic [2:0]      funct3,
   input  logic            is_imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OP_W-1:0] operation,
   output logic            illegal,
   output logic            busy
);

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Reject parameter values the decode and counter cannot represent.
   if (OP_W < 4 || MUL_LAT < 1 || MUL_LAT > 15 || DIV_LAT < 1 || DIV_LAT > 15) begin : g_param_check
      $error("alu_issue_ctrl: parameter out of range");
   end

`ifdef ALU_MEXT_EN
   localparam logic [6:0] F7_MEXT = 7'b0000001;
   localparam logic [3:0] MUL_CNT = 4'(int'(MUL_LAT) - 2);
   localparam logic [3:0] DIV_CNT = 4'(int'(DIV_LAT) - 2);
   localparam logic       MUL_LONG = (MUL_LAT >= 2);
   localparam logic       DIV_LONG = (DIV_LAT >= 2);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
   logic [3:0] cnt_q, cnt_d;
   logic       dec_long;
   logic [3:0] dec_cnt;
`else
   typedef enum logic {IDLE, HOLD} state_t;
`endif

   state_t          state_q, state_d;
   logic [OP_W-1:0] op_q, op_d;
   logic            ill_q, ill_d;
   logic [3:0]      rt_code, code;
   logic            rt_ill, dec_ill;
   logic [OP_W-1:0] dec_op;
   logic            accept;

   // R/I-type decode with funct7 legality; f3=011 has no code and is rejected.
   always_comb begin
      rt_code = 4'b0000;
      rt_ill  = 1'b0;
      case (funct3)
         3'b000: begin
            rt_code = (!is_imm && funct7 == F7_ALT) ? 4'b0011 : 4'b0010;
            rt_ill  = !is_imm && !(funct7 == F7_BASE || funct7 == F7_ALT);
         end
         3'b001: begin
            rt_code = 4'b0101;
            rt_ill  = (funct7 != F7_BASE);
         end
         3'b010: begin
            rt_code = 4'b0111;
            rt_ill  = !is_imm && (funct7 != F7_BASE);
         end
         3'b011: rt_ill = 1'b1;
         3'b100: begin
            rt_code = 4'b0100;
            rt_ill  = !is_imm && (funct7 != F7_BASE);
         end
         3'b101: begin
            rt_code = (funct7 == F7_ALT) ? 4'b1001 : 4'b0110;
            rt_ill  = !(funct7 == F7_BASE || funct7 == F7_ALT);
         end
         3'b110: begin
            rt_code = 4'b0001;
            rt_ill  = !is_imm && (funct7 != F7_BASE);
         end
         default: begin
            rt_code = 4'b0000;
            rt_ill  = !is_imm && (funct7 != F7_BASE);
         end
      endcase
   end

   // Top-level decode: select by alu_op, zero operation on illegal encodings.
   always_comb begin
      code    = 4'b0000;
      dec_ill = 1'b0;
      case (alu_op)
         2'b00: code = 4'b0010;
         2'b01: begin
            case (funct3)
               3'b000:  code = 4'b1000;
               3'b001:  code = 4'b1010;
               3'b100:  code = 4'b1011;
               3'b101:  code = 4'b1100;
               default: dec_ill = 1'b1;
            endcase
         end
         2'b10: begin
            code    = rt_code;
            dec_ill = rt_ill;
         end
         default: code = 4'b0000;
      endcase
      dec_op = '0;
      if (!dec_ill) dec_op[3:0] = code;
`ifdef ALU_MEXT_EN
      dec_long = 1'b0;
      dec_cnt  = funct3[2] ? DIV_CNT : MUL_CNT;
      if (alu_op == 2'b10 && funct7 == F7_MEXT && !is_imm) begin
         dec_ill      = 1'b0;
         dec_op       = '0;
         dec_op[4]    = 1'b1;
         dec_op[2:0]  = funct3;
         dec_long     = funct3[2] ? DIV_LONG : MUL_LONG;
      end
`endif
   end

   assign in_ready  = reset_n && !flush &&
                      (state_q == IDLE || (state_q == HOLD && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == HOLD);
   assign operation = op_q;
   assign illegal   = ill_q;
`ifdef ALU_MEXT_EN
   assign busy      = (state_q == BUSY);
`else
   assign busy      = 1'b0;
`endif

   // Next-state: flush wins; accept (which already excludes flush) loads a new op.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      ill_d   = ill_q;
`ifdef ALU_MEXT_EN
      cnt_d   = cnt_q;
`endif
      if (flush) begin
         state_d = IDLE;
`ifdef ALU_MEXT_EN
         cnt_d   = '0;
`endif
      end else if (accept) begin
         op_d    = dec_op;
         ill_d   = dec_ill;
         state_d = HOLD;
`ifdef ALU_MEXT_EN
         if (dec_long) begin
            state_d = BUSY;
            cnt_d   = dec_cnt;
         end
`endif
      end else begin
         case (state_q)
`ifdef ALU_MEXT_EN
            BUSY: begin
               if (cnt_q == '0) state_d = HOLD;
               else             cnt_d   = cnt_q - 4'd1;
            end
`endif
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   // State, held operation and latency counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         ill_q   <= 1'b0;
`ifdef ALU_MEXT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         ill_q   <= ill_d;
`ifdef ALU_MEXT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus random
// traffic compared with a timestamp-based transaction model.
module tb_alu_issue_ctrl;
   localparam int unsigned OP_W    = 5;
   localparam int unsigned MUL_LAT = 4;
   localparam int unsigned DIV_LAT = 8;

   logic            clk = 1'b0;
   logic            reset_n, flush, in_valid, in_ready;
   logic [1:0]      alu_op;
   logic [6:0]      funct7;
   logic [2:0]      funct3;
   logic            is_imm, out_valid, out_ready;
   logic [OP_W-1:0] operation;
   logic            illegal, busy;

   int errors = 0;
   int checks = 0;

   // transaction model: one pending op, visible once cyc reaches ready_at
   bit         have = 0;
   int         ready_at = 0;
   int         cyc = 0;
   logic [4:0] m_op = '0;
   logic       m_ill = 1'b0;
   logic       exp_valid, exp_busy, exp_ready;

   alu_issue_ctrl #(.OP_W(OP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready), .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
      .is_imm(is_imm), .out_valid(out_valid), .out_ready(out_ready),
      .operation(operation), .illegal(illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic ref_decode(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                             input logic imm, output logic [4:0] op, output logic ill, output int lat);
      bit shift, f7_ok;
      op = 5'd0; ill = 1'b0; lat = 1;
      shift = (f3 == 3'd1 || f3 == 3'd5);
      if (aop == 2'd0) op = 5'd2;
      else if (aop == 2'd3) op = 5'd0;
      else if (aop == 2'd1) begin
         case (f3)
            3'd0: op = 5'd8;
            3'd1: op = 5'd10;
            3'd4: op = 5'd11;
            3'd5: op = 5'd12;
            default: ill = 1'b1;
         endcase
      end
`ifdef ALU_MEXT_EN
      else if (f7 == 7'h01 && !imm) begin
         op  = {2'b10, f3};
         lat = (f3 < 3'd4) ? int'(MUL_LAT) : int'(DIV_LAT);
      end
`endif
      else begin
         if (shift) f7_ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
         else       f7_ok = imm || (f7 == 7'h00) || (f3 == 3'd0 && f7 == 7'h20);
         ill = !f7_ok || (f3 == 3'd3);
         case (f3)
            3'd0: op = (!imm && f7 == 7'h20) ? 5'd3 : 5'd2;
            3'd1: op = 5'd5;
            3'd2: op = 5'd7;
            3'd4: op = 5'd4;
            3'd5: op = (f7 == 7'h20) ? 5'd9 : 5'd6;
            3'd6: op = 5'd1;
            default: op = 5'd0;
         endcase
      end
      if (ill) op = 5'd0;
   endtask

   // apply inputs at the falling edge and compute the model's expectations
   task automatic drive(input logic v, input logic [1:0] aop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic imm, input logic ordy, input logic fl);
      @(negedge clk);
      in_valid = v; alu_op = aop; funct7 = f7; funct3 = f3; is_imm = imm;
      out_ready = ordy; flush = fl;
      #1;
      exp_valid = have && (cyc >= ready_at);
      exp_busy  = have && (cyc < ready_at);
      exp_ready = reset_n && !flush && (!have || (exp_valid && out_ready));
   endtask

   // step the model across one rising edge
   task automatic advance();
      logic [4:0] op;
      logic       ill;
      int         lat;
      @(posedge clk);
      if (!reset_n || flush) have = 0;
      else if (exp_ready && in_valid) begin
         ref_decode(alu_op, funct7, funct3, is_imm, op, ill, lat);
         have = 1; m_op = op; m_ill = ill; ready_at = cyc + lat;
      end else if (exp_valid && out_ready) have = 0;
      cyc++;
   endtask

   task automatic test_reset();
      reset_n = 1'b1; flush = 0; in_valid = 0; alu_op = 0; funct7 = 0; funct3 = 0;
      is_imm = 0; out_ready = 1;
      #1 reset_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (operation !== 5'd0) begin errors++; $display("FAIL rst_operation: got %h want 0", operation); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b want 0", illegal); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %b want 0", out_valid); end
      in_valid = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      have = 0;
   endtask

   task automatic test_decode_basic();
      drive(1, 2'b10, 7'h20, 3'b000, 0, 1, 0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sub_in_ready: got %b want 1", in_ready); end
      advance();
      drive(1, 2'b10, 7'h20, 3'b000, 1, 1, 0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_valid: got %b want 1", out_valid); end
      checks++; if (operation !== 5'b00011) begin errors++; $display("FAIL sub_op: got %b want 00011", operation); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL sub_illegal: got %b want 0", illegal); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
      advance();
      drive(1, 2'b01, 7'h00, 3'b110, 0, 1, 0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
      checks++; if (operation !== 5'b00010) begin errors++; $display("FAIL addi_op: got %b want 00010", operation); end
      advance();
      drive(0, 2'b00, 7'h00, 3'b000, 0, 1, 0);
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL br_illegal: got %b want 1", illegal); end
      checks++; if (operation !== 5'b00000) begin errors++; $display("FAIL br_op: got %b want 00000", operation); end
      advance();
      drive(0, 2'b00, 7'h00, 3'b000, 0, 1, 0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", out_valid); end
      advance();
   endtask

   task automatic test_backpressure();
      drive(1, 2'b10, 7'h00, 3'b100, 0, 1, 0);
      advance();
      for (int i = 0; i < 3; i++) begin
         drive(1, 2'b10, 7'h00, 3'b110, 0, 0, 0);
         checks++; if (operation !== 5'b00100) begin errors++; $display("FAIL bp_op_stable[%0d]: got %b want 00100", i, operation); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
         advance();
      end
      drive(1, 2'b10, 7'h00, 3'b110, 0, 1, 0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      advance();
      drive(0, 2'b00, 7'h00, 3'b000, 0, 0, 0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
      checks++; if (operation !== 5'b00001) begin errors++; $display("FAIL bp_next_op: got %b want 00001", operation); end
      advance();
      drive(0, 2'b00, 7'h00, 3'b000, 0, 1, 0);
      advance();
   endtask

   task automatic test_flush();
      drive(1, 2'b00, 7'h00, 3'b000, 0, 1, 0);
      advance();
      drive(1, 2'b00, 7'h00, 3'b000, 0, 1, 1);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
      advance();
      drive(0, 2'b00, 7'h00, 3'b000, 0, 1, 0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_ready: got %b want 1", in_ready); end
      advance();
`ifdef ALU_MEXT_EN
      drive(1, 2'b10, 7'h01, 3'b000, 0, 1, 0);
      advance();
      for (int i = 0; i < 3; i++) begin
         drive(0, 2'b00, 7'h00, 3'b000, 0, 1, (i == 2) ? 1'b1 : 1'b0);
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy[%0d]: got %b want 1", i, busy); end
         advance();
      end
      for (int i = 0; i < 5; i++) begin
         drive(0, 2'b00, 7'h00, 3'b000, 0, 1, 0);
         checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mul_flushed[%0d]: got valid=%b busy=%b want 0 0", i, out_valid, busy);
         end
         advance();
      end
`endif
   endtask

`ifdef ALU_MEXT_EN
   task automatic test_div_latency();
      drive(1, 2'b10, 7'h01, 3'b100, 0, 1, 0);
      advance();
      for (int k = 1; k <= 7; k++) begin
         drive(0, 2'b00, 7'h00, 3'b000, 0, 1, 0);
         checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL div_wait[%0d]: got busy=%b rdy=%b valid=%b want 1 0 0", k, busy, in_ready, out_valid);
         end
         advance();
      end
      drive(0, 2'b00, 7'h00, 3'b000, 0, 1, 0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL div_valid: got %b want 1", out_valid); end
      checks++; if (operation !== 5'b10100) begin errors++; $display("FAIL div_op: got %b want 10100", operation); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_busy_done: got %b want 0", busy); end
      advance();
   endtask
`endif

   task automatic test_reset_mid();
      drive(1, 2'b00, 7'h00, 3'b000, 0, 1, 0);
      advance();
      drive(0, 2'b00, 7'h00, 3'b000, 0, 0, 0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b want 1", out_valid); end
      reset_n = 1'b0;
      #1;
      have = 0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
      checks++; if (operation !== 5'd0) begin errors++; $display("FAIL rmid_op: got %b want 0", operation); end
      advance();
      #2 reset_n = 1'b1;
      drive(1, 2'b10, 7'h00, 3'b111, 0, 1, 0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_release_ready: got %b want 1", in_ready); end
      advance();
      drive(0, 2'b00, 7'h00, 3'b000, 0, 1, 0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_first_valid: got %b want 1", out_valid); end
      advance();
   endtask

   task automatic test_random();
      logic       v, imm, ordy, fl;
      logic [1:0] aop;
      logic [2:0] f3;
      logic [6:0] f7;
      for (int n = 0; n < 400; n++) begin
         v    = 1'($urandom_range(0, 3) != 0);
         aop  = 2'($urandom_range(0, 3));
         f3   = 3'($urandom_range(0, 7));
         imm  = 1'($urandom_range(0, 1));
         ordy = 1'($urandom_range(0, 3) != 0);
         fl   = 1'($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
         endcase
         drive(v, aop, f7, f3, imm, ordy, fl);
         checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, exp_valid); end
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", n, busy, exp_busy); end
         checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", n, in_ready, exp_ready); end
         if (exp_valid) begin
            checks++; if (operation !== m_op || illegal !== m_ill) begin
               errors++; $display("FAIL rnd_op[%0d]: got op=%b ill=%b want op=%b ill=%b", n, operation, illegal, m_op, m_ill);
            end
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_decode_basic();
      test_backpressure();
      test_flush();
`ifdef ALU_MEXT_EN
      test_div_latency();
`endif
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter OP_W, default 5, operation code width; SHALL be >= 5 with ALU_MEXT_EN defined, >= 4 otherwise.
REQ-002 Parameter MUL_LAT, default 2, accept-to-out_valid latency in cycles for multiply ops; range 1..15.
REQ-003 Parameter DIV_LAT, default 8, accept-to-out_valid latency in cycles for divide/remainder ops; range 1..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  synchronous pipeline flush; discards the held or in-flight op.
REQ-007 in_valid  in  1  decode request valid.
REQ-008 in_ready  out  1  block can accept a request this cycle.
REQ-009 alu_op  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
REQ-010 funct7  in  7  instruction bits 31:25.
REQ-011 funct3  in  3  instruction bits 14:12.
REQ-012 is_imm  in  1  1 = I-type; funct7 ignored except for shifts.
REQ-013 out_valid  out  1  operation/illegal valid.
REQ-014 out_ready  in  1  downstream accepts output.
REQ-015 operation  out  OP_W  ALU operation code, zero-extended to OP_W.
REQ-016 illegal  out  1  unsupported encoding.
REQ-017 busy  out  1  multi-cycle op in progress.

Function
REQ-018 Decode: alu_op 00 -> ADD 0010; alu_op 11 -> 0000.
REQ-019 alu_op 10: f3 000 ADD 0010 (SUB 0011 if f7=0100000 and is_imm=0); 001 SLL 0101; 010 SLT 0111; 100 XOR 0100; 101 SRL 0110 / SRA 1001; 110 OR 0001; 111 AND 0000.
REQ-020 alu_op 10 legality: shifts (001,101) require f7=0000000 (or 0100000 for 101) regardless of is_imm; with is_imm=0, other f3 require f7=0000000 (or 0100000 for 000); otherwise illegal=1, operation=0.
REQ-021 alu_op 01: f3 000 BEQ 1000, 001 BNE 1010, 100 BLT 1011, 101 BGE 1100; other f3 -> illegal=1, operation=0.
REQ-022 FSM states IDLE, BUSY, HOLD; accept = in_valid && in_ready.
REQ-023 in_ready = !flush && (IDLE || (HOLD && out_ready)).
REQ-024 Single-cycle op (all non-M and illegal ops): accept -> HOLD next edge, out_valid=1 (latency 1).
REQ-025 M op with LAT>=2: accept -> BUSY, counter loaded LAT-2, decremented each cycle; BUSY && counter==0 -> HOLD; out_valid rises exactly LAT edges after the accept edge; LAT=1 behaves as single-cycle.
REQ-026 HOLD && out_ready && no accept -> IDLE; HOLD && out_ready && accept -> back-to-back load of new op.
REQ-027 operation and illegal SHALL be registered and stable while out_valid && !out_ready.
REQ-028 flush has priority over all transitions: next state IDLE, out_valid=0, counter=0, no accept in that cycle.
REQ-029 busy = (state==BUSY); out_valid = (state==HOLD).

Reset
REQ-030 reset_n low SHALL immediately force IDLE, out_valid=0, operation=0, illegal=0, busy=0, counter=0, in_ready=0.
REQ-031 Reset asserted mid-BUSY or mid-HOLD SHALL discard the op; first accept possible on the first edge after release.

Configuration
REQ-032 Macro ALU_MEXT_EN defined: alu_op 10 with f7=0000001 and is_imm=0 decodes to operation {1'b1, 1'b0, f3} (MUL..REMU = 10000..10111); f3 0xx uses MUL_LAT, 1xx uses DIV_LAT.
REQ-033 ALU_MEXT_EN undefined: f7=0000001 is illegal (latency 1), busy is constant 0, BUSY state and counter are not implemented.

Verification
REQ-034 After reset, in_valid=1, alu_op=10, f3=000, f7=0100000, is_imm=0 -> next cycle out_valid=1, operation=00011, illegal=0.
REQ-035 Same with is_imm=1 -> operation=00010; alu_op=01, f3=110 -> illegal=1, operation=0.
REQ-036 ALU_MEXT_EN, DIV_LAT=8: DIV (f7=0000001, f3=100) accepted at edge 0 -> busy=1 edges 1..7, in_ready=0, out_valid=1 at edge 8, operation=10100.
REQ-037 out_ready=0 for 3 cycles in HOLD -> operation stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op loaded, out_valid stays 1.
REQ-038 flush in BUSY cycle 3 of MUL_LAT=4 op -> IDLE next edge, out_valid never asserted; reset_n low in HOLD -> out_valid=0 immediately.
